// File: rtl/ddr_axi_pkg.sv
// Shared types and AXI encodings for the cache-line DRAM master.
package ddr_axi_pkg;
  localparam int unsigned LINE_BYTES     = 16;
  localparam int unsigned LINE_LSB       = $clog2(LINE_BYTES);
  localparam logic [2:0]  AXI_SIZE_LINE  = 3'b100;
  localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
  localparam logic [3:0]  AXI_CACHE_DEF  = 4'b0011;
  localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;

  typedef enum logic [1:0] {W_IDLE, W_SEND, W_RESP} wr_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA, R_HOLD} rd_state_t;
endpackage

// File: rtl/ddr_line_axi_wr.sv
// Write engine: one 128-bit line per single-beat AXI4 write burst.
module ddr_line_axi_wr
  import ddr_axi_pkg::*;
#(
  parameter int unsigned ADDR_W = 27,
  parameter int unsigned DATA_W = 128
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  output logic [ADDR_W-1:0]      M_AXI_AWADDR,
  output logic [7:0]             M_AXI_AWLEN,
  output logic [2:0]             M_AXI_AWSIZE,
  output logic [1:0]             M_AXI_AWBURST,
  output logic                   M_AXI_AWLOCK,
  output logic [3:0]             M_AXI_AWCACHE,
  output logic [2:0]             M_AXI_AWPROT,
  output logic [3:0]             M_AXI_AWQOS,
  output logic                   M_AXI_AWVALID,
  input  logic                   M_AXI_AWREADY,
  output logic [DATA_W-1:0]      M_AXI_WDATA,
  output logic [DATA_W/8-1:0]    M_AXI_WSTRB,
  output logic                   M_AXI_WLAST,
  output logic                   M_AXI_WVALID,
  input  logic                   M_AXI_WREADY,
  input  logic [1:0]             M_AXI_BRESP,
  input  logic                   M_AXI_BVALID,
  output logic                   M_AXI_BREADY,
  output logic                   wr_busy_nxt,
  output logic [ADDR_W-LINE_LSB-1:0] wr_line_nxt,
  output logic                   b_err
);
  wr_state_t         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic              aw_done, w_done;
  logic              unused_lsb;

  assign unused_lsb = ^wr_addr[LINE_LSB-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= W_IDLE;
      addr_q    <= '0;
      data_q    <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    data_d    = data_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    b_err     = 1'b0;
    // A channel counts as done once its valid has already dropped or it handshakes now.
    aw_done   = !awvalid_q || M_AXI_AWREADY;
    w_done    = !wvalid_q || M_AXI_WREADY;
    unique case (state_q)
      W_IDLE: if (wr_valid) begin
        addr_d    = {wr_addr[ADDR_W-1:LINE_LSB], {LINE_LSB{1'b0}}};
        data_d    = wr_data;
        awvalid_d = 1'b1;
        wvalid_d  = 1'b1;
        state_d   = W_SEND;
      end
      W_SEND: begin
        if (M_AXI_AWREADY) awvalid_d = 1'b0;
        if (M_AXI_WREADY)  wvalid_d  = 1'b0;
        if (aw_done && w_done) begin
          bready_d = 1'b1;
          state_d  = W_RESP;
        end
      end
      W_RESP: if (M_AXI_BVALID) begin
        bready_d = 1'b0;
        b_err    = (M_AXI_BRESP != AXI_RESP_OKAY);
        state_d  = W_IDLE;
      end
      default: state_d = W_IDLE;
    endcase
  end

  // Next-state view lets the read engine register ARVALID without a cycle of lag.
  assign wr_busy_nxt = (state_d != W_IDLE);
  assign wr_line_nxt = addr_d[ADDR_W-1:LINE_LSB];
  assign wr_ready    = (state_q == W_IDLE);

  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWLEN   = 8'd0;
  assign M_AXI_AWSIZE  = AXI_SIZE_LINE;
  assign M_AXI_AWBURST = AXI_BURST_INCR;
  assign M_AXI_AWLOCK  = 1'b0;
  assign M_AXI_AWCACHE = AXI_CACHE_DEF;
  assign M_AXI_AWPROT  = 3'd0;
  assign M_AXI_AWQOS   = 4'd0;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = data_q;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_WLAST   = 1'b1;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
endmodule

// File: rtl/ddr_line_axi.sv
// Cache-line DRAM master: line write-backs and fills as single-beat AXI4 bursts.
module ddr_line_axi
  import ddr_axi_pkg::*;
#(
  parameter int unsigned ADDR_W = 27,
  parameter int unsigned DATA_W = 128
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [ADDR_W-1:0]   rd_addr,
  input  logic                rd_avalid,
  output logic                rd_aready,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_valid,
  input  logic                rd_dready,
  output logic                axi_err,
  output logic [ADDR_W-1:0]   M_AXI_AWADDR,
  output logic [7:0]          M_AXI_AWLEN,
  output logic [2:0]          M_AXI_AWSIZE,
  output logic [1:0]          M_AXI_AWBURST,
  output logic                M_AXI_AWLOCK,
  output logic [3:0]          M_AXI_AWCACHE,
  output logic [2:0]          M_AXI_AWPROT,
  output logic [3:0]          M_AXI_AWQOS,
  output logic                M_AXI_AWVALID,
  input  logic                M_AXI_AWREADY,
  output logic [DATA_W-1:0]   M_AXI_WDATA,
  output logic [DATA_W/8-1:0] M_AXI_WSTRB,
  output logic                M_AXI_WLAST,
  output logic                M_AXI_WVALID,
  input  logic                M_AXI_WREADY,
  input  logic [1:0]          M_AXI_BRESP,
  input  logic                M_AXI_BVALID,
  output logic                M_AXI_BREADY,
  output logic [ADDR_W-1:0]   M_AXI_ARADDR,
  output logic [7:0]          M_AXI_ARLEN,
  output logic [2:0]          M_AXI_ARSIZE,
  output logic [1:0]          M_AXI_ARBURST,
  output logic                M_AXI_ARLOCK,
  output logic [3:0]          M_AXI_ARCACHE,
  output logic [2:0]          M_AXI_ARPROT,
  output logic [3:0]          M_AXI_ARQOS,
  output logic                M_AXI_ARVALID,
  input  logic                M_AXI_ARREADY,
  input  logic [DATA_W-1:0]   M_AXI_RDATA,
  input  logic [1:0]          M_AXI_RRESP,
  input  logic                M_AXI_RLAST,
  input  logic                M_AXI_RVALID,
  output logic                M_AXI_RREADY
);
  rd_state_t                 state_q, state_d;
  logic [ADDR_W-1:0]         addr_q, addr_d;
  logic [DATA_W-1:0]         rdata_q, rdata_d;
  logic                      arvalid_q, arvalid_d, rready_q, rready_d;
  logic                      rvalid_q, rvalid_d, err_q, err_d;
  logic                      wr_busy_nxt, b_err;
  logic [ADDR_W-LINE_LSB-1:0] wr_line_nxt;
  logic                      unused_lsb;

  assign unused_lsb = ^rd_addr[LINE_LSB-1:0];

  ddr_line_axi_wr #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_wr (
    .clk(clk), .rst_n(rst_n),
    .wr_data(wr_data), .wr_addr(wr_addr), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWLEN(M_AXI_AWLEN), .M_AXI_AWSIZE(M_AXI_AWSIZE),
    .M_AXI_AWBURST(M_AXI_AWBURST), .M_AXI_AWLOCK(M_AXI_AWLOCK), .M_AXI_AWCACHE(M_AXI_AWCACHE),
    .M_AXI_AWPROT(M_AXI_AWPROT), .M_AXI_AWQOS(M_AXI_AWQOS), .M_AXI_AWVALID(M_AXI_AWVALID),
    .M_AXI_AWREADY(M_AXI_AWREADY), .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
    .M_AXI_WLAST(M_AXI_WLAST), .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
    .wr_busy_nxt(wr_busy_nxt), .wr_line_nxt(wr_line_nxt), .b_err(b_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= R_IDLE;
      addr_q    <= '0;
      rdata_q   <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rdata_q   <= rdata_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      rvalid_q  <= rvalid_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rdata_d   = rdata_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    rvalid_d  = rvalid_q;
    err_d     = err_q | b_err;
    unique case (state_q)
      R_IDLE: if (rd_avalid) begin
        addr_d  = {rd_addr[ADDR_W-1:LINE_LSB], {LINE_LSB{1'b0}}};
        state_d = R_ADDR;
      end
      R_ADDR: if (arvalid_q && M_AXI_ARREADY) begin
        arvalid_d = 1'b0;
        rready_d  = 1'b1;
        state_d   = R_DATA;
      end
      R_DATA: if (M_AXI_RVALID) begin
        rdata_d  = M_AXI_RDATA;
        rready_d = 1'b0;
        rvalid_d = 1'b1;
        if (M_AXI_RRESP != AXI_RESP_OKAY || !M_AXI_RLAST) err_d = 1'b1;
        state_d  = R_HOLD;
      end
      R_HOLD: if (rd_dready) begin
        rvalid_d = 1'b0;
        state_d  = R_IDLE;
      end
      default: state_d = R_IDLE;
    endcase
    // ARVALID only rises when the line is clear next cycle; once up it stays until ARREADY.
    if (state_d == R_ADDR && !arvalid_q)
      arvalid_d = !(wr_busy_nxt && (wr_line_nxt == addr_d[ADDR_W-1:LINE_LSB]));
  end

  assign rd_aready = (state_q == R_IDLE);
  assign rd_data   = rdata_q;
  assign rd_valid  = rvalid_q;
  assign axi_err   = err_q;

  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARLEN   = 8'd0;
  assign M_AXI_ARSIZE  = AXI_SIZE_LINE;
  assign M_AXI_ARBURST = AXI_BURST_INCR;
  assign M_AXI_ARLOCK  = 1'b0;
  assign M_AXI_ARCACHE = AXI_CACHE_DEF;
  assign M_AXI_ARPROT  = 3'd0;
  assign M_AXI_ARQOS   = 4'd0;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;
endmodule

// File: tb/tb_ddr_line_axi.sv
// Directed bench for ddr_line_axi: vector table plus hand-written hazard/error/reset sequences.
module tb_ddr_line_axi;
  logic         clk, rst_n;
  logic [127:0] wr_data;
  logic [26:0]  wr_addr;
  logic         wr_valid, wr_ready;
  logic [26:0]  rd_addr;
  logic         rd_avalid, rd_aready;
  logic [127:0] rd_data;
  logic         rd_valid, rd_dready, axi_err;
  logic [26:0]  M_AXI_AWADDR, M_AXI_ARADDR;
  logic [7:0]   M_AXI_AWLEN, M_AXI_ARLEN;
  logic [2:0]   M_AXI_AWSIZE, M_AXI_ARSIZE, M_AXI_AWPROT, M_AXI_ARPROT;
  logic [1:0]   M_AXI_AWBURST, M_AXI_ARBURST, M_AXI_BRESP, M_AXI_RRESP;
  logic         M_AXI_AWLOCK, M_AXI_ARLOCK;
  logic [3:0]   M_AXI_AWCACHE, M_AXI_ARCACHE, M_AXI_AWQOS, M_AXI_ARQOS;
  logic         M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY, M_AXI_WLAST;
  logic [127:0] M_AXI_WDATA, M_AXI_RDATA;
  logic [15:0]  M_AXI_WSTRB;
  logic         M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
  logic         M_AXI_RLAST, M_AXI_RVALID, M_AXI_RREADY;

  int n_cmp = 0;
  int n_err = 0;
  int aw_hs = 0;
  int w_hs  = 0;

  ddr_line_axi #(.ADDR_W(27), .DATA_W(128)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_data(wr_data), .wr_addr(wr_addr), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_addr(rd_addr), .rd_avalid(rd_avalid), .rd_aready(rd_aready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_dready(rd_dready), .axi_err(axi_err),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWLEN(M_AXI_AWLEN), .M_AXI_AWSIZE(M_AXI_AWSIZE),
    .M_AXI_AWBURST(M_AXI_AWBURST), .M_AXI_AWLOCK(M_AXI_AWLOCK), .M_AXI_AWCACHE(M_AXI_AWCACHE),
    .M_AXI_AWPROT(M_AXI_AWPROT), .M_AXI_AWQOS(M_AXI_AWQOS), .M_AXI_AWVALID(M_AXI_AWVALID),
    .M_AXI_AWREADY(M_AXI_AWREADY), .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
    .M_AXI_WLAST(M_AXI_WLAST), .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARLEN(M_AXI_ARLEN), .M_AXI_ARSIZE(M_AXI_ARSIZE),
    .M_AXI_ARBURST(M_AXI_ARBURST), .M_AXI_ARLOCK(M_AXI_ARLOCK), .M_AXI_ARCACHE(M_AXI_ARCACHE),
    .M_AXI_ARPROT(M_AXI_ARPROT), .M_AXI_ARQOS(M_AXI_ARQOS), .M_AXI_ARVALID(M_AXI_ARVALID),
    .M_AXI_ARREADY(M_AXI_ARREADY), .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
    .M_AXI_RLAST(M_AXI_RLAST), .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n && M_AXI_AWVALID && M_AXI_AWREADY) aw_hs <= aw_hs + 1;
    if (rst_n && M_AXI_WVALID && M_AXI_WREADY)   w_hs  <= w_hs + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation still running, expected completion");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    wr_data = '0; wr_addr = '0; wr_valid = 0; rd_addr = '0; rd_avalid = 0; rd_dready = 0;
    M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BRESP = 0; M_AXI_BVALID = 0;
    M_AXI_ARREADY = 0; M_AXI_RDATA = '0; M_AXI_RRESP = 0; M_AXI_RLAST = 0; M_AXI_RVALID = 0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_wr_ready"}, wr_ready, 1);
    chk({tag, "_rd_aready"}, rd_aready, 1);
    chk({tag, "_valids"}, {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, M_AXI_BREADY, M_AXI_RREADY, rd_valid}, 0);
  endtask

  // Called at a negedge with the write engine idle.
  task automatic do_write(input logic [26:0] a, input logic [127:0] d, input logic [26:0] ea,
                          input int awd, input int wd, input int bd, input logic [1:0] br);
    int aw0, w0, last;
    aw0 = aw_hs; w0 = w_hs;
    chk("w_ready_idle", wr_ready, 1);
    wr_addr = a; wr_data = d; wr_valid = 1;
    @(negedge clk);
    wr_valid = 0;
    chk("w_ready_low", wr_ready, 0);
    chk("w_awaddr", M_AXI_AWADDR, ea);
    chk("w_wdata", M_AXI_WDATA, d);
    chk("w_const", {M_AXI_WSTRB, M_AXI_WLAST, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST,
                    M_AXI_AWLOCK, M_AXI_AWCACHE, M_AXI_AWPROT, M_AXI_AWQOS},
        {16'hFFFF, 1'b1, 8'h00, 3'b100, 2'b01, 1'b0, 4'b0011, 3'b000, 4'h0});
    last = (awd > wd) ? awd : wd;
    for (int k = 0; k <= last; k++) begin
      chk("w_awvalid", M_AXI_AWVALID, k <= awd);
      chk("w_wvalid", M_AXI_WVALID, k <= wd);
      chk("w_bready_early", M_AXI_BREADY, 0);
      M_AXI_AWREADY = (k == awd);
      M_AXI_WREADY  = (k == wd);
      @(negedge clk);
    end
    M_AXI_AWREADY = 0; M_AXI_WREADY = 0;
    chk("w_valids_dropped", {M_AXI_AWVALID, M_AXI_WVALID}, 0);
    for (int j = 0; j <= bd; j++) begin
      chk("w_bready", M_AXI_BREADY, 1);
      chk("w_ready_resp", wr_ready, 0);
      M_AXI_BVALID = (j == bd);
      M_AXI_BRESP  = br;
      @(negedge clk);
    end
    M_AXI_BVALID = 0; M_AXI_BRESP = 0;
    chk("w_ready_back", wr_ready, 1);
    chk("w_bready_off", M_AXI_BREADY, 0);
    chk("w_aw_count", aw_hs - aw0, 1);
    chk("w_w_count", w_hs - w0, 1);
  endtask

  // Called at a negedge with the read engine idle.
  task automatic do_read(input logic [26:0] a, input logic [26:0] ea, input logic [127:0] rdat,
                         input int ard, input int rdl, input logic [1:0] rr, input logic rl,
                         input int hold);
    chk("r_aready_idle", rd_aready, 1);
    rd_addr = a; rd_avalid = 1;
    @(negedge clk);
    rd_avalid = 0;
    chk("r_aready_low", rd_aready, 0);
    chk("r_araddr", M_AXI_ARADDR, ea);
    chk("r_const", {M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST, M_AXI_ARLOCK, M_AXI_ARCACHE,
                    M_AXI_ARPROT, M_AXI_ARQOS}, {8'h00, 3'b100, 2'b01, 1'b0, 4'b0011, 3'b000, 4'h0});
    for (int k = 0; k <= ard; k++) begin
      chk("r_arvalid", M_AXI_ARVALID, 1);
      chk("r_rready_early", M_AXI_RREADY, 0);
      M_AXI_ARREADY = (k == ard);
      @(negedge clk);
    end
    M_AXI_ARREADY = 0;
    chk("r_arvalid_off", M_AXI_ARVALID, 0);
    for (int j = 0; j <= rdl; j++) begin
      chk("r_rready", M_AXI_RREADY, 1);
      chk("r_valid_early", rd_valid, 0);
      M_AXI_RVALID = (j == rdl);
      M_AXI_RDATA  = (j == rdl) ? rdat : '0;
      M_AXI_RRESP  = rr;
      M_AXI_RLAST  = rl;
      @(negedge clk);
    end
    M_AXI_RVALID = 0; M_AXI_RDATA = '0; M_AXI_RRESP = 0; M_AXI_RLAST = 0;
    chk("r_rready_off", M_AXI_RREADY, 0);
    for (int h = 0; h <= hold; h++) begin
      chk("r_valid", rd_valid, 1);
      chk("r_data", rd_data, rdat);
      rd_dready = (h == hold);
      @(negedge clk);
    end
    rd_dready = 0;
    chk("r_valid_off", rd_valid, 0);
    chk("r_aready_back", rd_aready, 1);
  endtask

  typedef struct {
    bit           is_rd;
    logic [26:0]  addr;
    logic [127:0] data;
    logic [26:0]  exp_addr;
    int           d0;  // AW or AR ready delay
    int           d1;  // W ready delay, or R beat delay
    int           d2;  // B delay, or rd_dready hold
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{0, 27'h0001234, {16{8'hA5}}, 27'h0001230, 0, 0, 2};
    vecs[1] = '{1, 27'h0000040, 128'h0123456789ABCDEF0123456789ABCDEF, 27'h0000040, 0, 2, 3};
    vecs[2] = '{0, 27'h0000550, 128'hDEADBEEF_00000000_CAFEF00D_12345678, 27'h0000550, 1, 4, 0};
    vecs[3] = '{0, 27'h7FFFFFF, 128'hFFFF_0000_FFFF_0000_FFFF_0000_FFFF_0001, 27'h7FFFFF0, 2, 0, 1};
    vecs[4] = '{1, 27'h000000F, 128'h1, 27'h0000000, 2, 0, 0};
    vecs[5] = '{1, 27'h5A5A5A7, 128'h8000_0000_0000_0000_0000_0000_0000_0000, 27'h5A5A5A0, 0, 1, 1};

    clear_inputs();
    rst_n = 0;
    #12;
    chk_idle("rst");
    chk("rst_rd_data", rd_data, 0);
    chk("rst_err", axi_err, 0);
    chk("rst_addrs", {M_AXI_AWADDR, M_AXI_ARADDR}, 0);
    chk("rst_wdata", M_AXI_WDATA, 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      if (vecs[i].is_rd)
        do_read(vecs[i].addr, vecs[i].exp_addr, vecs[i].data, vecs[i].d0, vecs[i].d1, 2'b00, 1'b1, vecs[i].d2);
      else
        do_write(vecs[i].addr, vecs[i].data, vecs[i].exp_addr, vecs[i].d0, vecs[i].d1, vecs[i].d2, 2'b00);
      chk("vec_no_err", axi_err, 0);
    end

    // Same-line hazard: fill must wait for the write-back to finish.
    wr_addr = 27'h0000100; wr_data = {4{32'h5555AAAA}}; wr_valid = 1;
    rd_addr = 27'h0000104; rd_avalid = 1;
    @(negedge clk);
    wr_valid = 0; rd_avalid = 0;
    chk("haz_both_accepted", {wr_ready, rd_aready}, 0);
    chk("haz_arvalid_send", M_AXI_ARVALID, 0);
    M_AXI_AWREADY = 1; M_AXI_WREADY = 1;
    @(negedge clk);
    M_AXI_AWREADY = 0; M_AXI_WREADY = 0;
    chk("haz_bready", M_AXI_BREADY, 1);
    for (int j = 0; j <= 5; j++) begin
      chk("haz_arvalid_hold", M_AXI_ARVALID, 0);
      M_AXI_BVALID = (j == 5);
      @(negedge clk);
    end
    M_AXI_BVALID = 0;
    chk("haz_wr_idle", wr_ready, 1);
    chk("haz_arvalid_rise", M_AXI_ARVALID, 1);
    chk("haz_araddr", M_AXI_ARADDR, 27'h0000100);
    M_AXI_ARREADY = 1;
    @(negedge clk);
    M_AXI_ARREADY = 0;
    M_AXI_RVALID = 1; M_AXI_RLAST = 1; M_AXI_RDATA = 128'h600D;
    @(negedge clk);
    M_AXI_RVALID = 0; M_AXI_RLAST = 0; M_AXI_RDATA = '0;
    chk("haz_rd_data", {rd_valid, rd_data}, {1'b1, 128'h600D});
    rd_dready = 1;
    @(negedge clk);
    rd_dready = 0;
    chk("haz_rd_idle", rd_aready, 1);

    // Different lines: read address goes out immediately, engines run concurrently.
    wr_addr = 27'h0000200; wr_data = 128'h77; wr_valid = 1;
    rd_addr = 27'h0000300; rd_avalid = 1;
    @(negedge clk);
    wr_valid = 0; rd_avalid = 0;
    chk("nohaz_arvalid", M_AXI_ARVALID, 1);
    chk("nohaz_awvalid", M_AXI_AWVALID, 1);
    M_AXI_AWREADY = 1; M_AXI_WREADY = 1; M_AXI_ARREADY = 1;
    @(negedge clk);
    M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_ARREADY = 0;
    chk("nohaz_readies", {M_AXI_BREADY, M_AXI_RREADY}, 2'b11);
    M_AXI_BVALID = 1; M_AXI_RVALID = 1; M_AXI_RLAST = 1; M_AXI_RDATA = 128'hBEEF;
    @(negedge clk);
    M_AXI_BVALID = 0; M_AXI_RVALID = 0; M_AXI_RLAST = 0; M_AXI_RDATA = '0;
    chk("nohaz_wr_done", wr_ready, 1);
    chk("nohaz_rd_data", {rd_valid, rd_data}, {1'b1, 128'hBEEF});
    rd_dready = 1;
    @(negedge clk);
    rd_dready = 0;
    chk_idle("nohaz_end");
    chk("nohaz_no_err", axi_err, 0);

    // Error responses: sticky, transfers still complete.
    do_write(27'h0000A00, 128'h1234, 27'h0000A00, 0, 0, 0, 2'b10);
    chk("err_bresp", axi_err, 1);
    do_write(27'h0000B00, 128'h5678, 27'h0000B00, 0, 0, 0, 2'b00);
    chk("err_sticky_w", axi_err, 1);
    apply_reset();
    chk("err_cleared", axi_err, 0);
    do_read(27'h0000C00, 27'h0000C00, 128'hC0FFEE, 0, 0, 2'b00, 1'b0, 0);
    chk("err_rlast", axi_err, 1);
    do_read(27'h0000D00, 27'h0000D00, 128'hD00D, 0, 0, 2'b00, 1'b1, 0);
    chk("err_sticky_r", axi_err, 1);
    apply_reset();

    // Reset mid-read (R_DATA) with a write also in flight.
    rd_addr = 27'h0000080; rd_avalid = 1;
    @(negedge clk);
    rd_avalid = 0; M_AXI_ARREADY = 1;
    wr_addr = 27'h0000400; wr_data = 128'h99; wr_valid = 1;
    @(negedge clk);
    M_AXI_ARREADY = 0; wr_valid = 0;
    chk("mid_rready", M_AXI_RREADY, 1);
    chk("mid_awvalid", M_AXI_AWVALID, 1);
    #2 rst_n = 0;
    #1;
    chk_idle("mid_rst");
    chk("mid_rst_addr", M_AXI_AWADDR, 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    do_read(27'h0000090, 27'h0000090, 128'hABCD_EF01, 1, 1, 2'b00, 1'b1, 0);
    chk("mid_no_err", axi_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
